// File: rtl/regfile_wr_sched_pkg.sv
// Shared types and defaults for the tile regfile control path.
// Also consumed by the regfile bench.
package regfile_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD
  } sched_state_e;

  localparam int RF_NUM_WR      = 3;
  localparam int RF_ACK_TIMEOUT = 16;
  localparam int RF_WR_BURST    = 4;
  localparam int RF_RD_MAX      = 8;

endpackage

// File: rtl/regfile_wr_sched_if.sv
// Scheduler <-> requesters/regfile signal bundle.
// slave is the scheduler side; master is the tile/regfile side.
interface regfile_wr_sched_if #(
  parameter int N = regfile_ctrl_pkg::RF_NUM_WR
) ();

  logic [N-1:0] wr_req;
  logic [N-1:0] wr_done;
  logic [N-1:0] wr_err;
  logic [N-1:0] rf_wen;
  logic [N-1:0] rf_ack;
  logic         rd_req;
  logic         rd_gnt;
  logic         rf_ren;
  logic         busy;

  modport master (
    output wr_req, rd_req, rf_ack,
    input  wr_done, wr_err, rd_gnt,
    input  rf_wen, rf_ren, busy
  );

  modport slave (
    input  wr_req, rd_req, rf_ack,
    output wr_done, wr_err, rd_gnt,
    output rf_wen, rf_ren, busy
  );

endinterface

// File: rtl/regfile_wr_sched_rr_pick.sv
// Combinational round-robin picker: first set req bit
// at or after ptr, wrapping.
module rr_pick #(
  parameter  int N = 3,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         any
);

  int j;

  // Walk offsets high to low so the smallest offset wins.
  always_comb begin
    gnt_idx = '0;
    any     = |req;
    j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) gnt_idx = W'(j);
    end
  end

endmodule

// File: rtl/regfile_wr_sched.sv
// Regfile control sequencer: round-robin write grants,
// ack/timeout tracking, read/write exclusion.
module regfile_wr_sched #(
  parameter int NUM_WR      = regfile_ctrl_pkg::RF_NUM_WR,
  parameter int ACK_TIMEOUT = regfile_ctrl_pkg::RF_ACK_TIMEOUT,
  parameter int WR_BURST    = regfile_ctrl_pkg::RF_WR_BURST,
  parameter int RD_MAX      = regfile_ctrl_pkg::RF_RD_MAX
) (
  input logic               clk,
  input logic               reset,
  regfile_wr_sched_if.slave bus
);

  import regfile_ctrl_pkg::*;

  localparam int PW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int SW = $clog2(WR_BURST + 1);
  localparam int RW = $clog2(RD_MAX + 1);

  sched_state_e      state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     pick_idx;
  logic [PW-1:0]     ptr_nxt;
  logic              pick_any;
  logic [NUM_WR-1:0] pick_oh;
  logic [TW-1:0]     tmr;
  logic [SW-1:0]     wr_streak;
  logic [RW-1:0]     rd_tmr;
  logic [NUM_WR-1:0] wen_q;
  logic [NUM_WR-1:0] done_q;
  logic [NUM_WR-1:0] err_q;
  logic              ren_q;
  logic              busy_q;
  logic              ack_hit;
  logic              rd_win;

  rr_pick #(
    .N(NUM_WR)
  ) u_pick (
    .req    (bus.wr_req),
    .ptr    (rr_ptr),
    .gnt_idx(pick_idx),
    .any    (pick_any)
  );

  assign pick_oh = {{(NUM_WR-1){1'b0}}, 1'b1} << pick_idx;
  assign ptr_nxt = (pick_idx == PW'(NUM_WR - 1))
                 ? '0 : pick_idx + PW'(1);

  // wen_q is onehot(g), so masking drops acks from other ports.
  assign ack_hit = |(bus.rf_ack & wen_q);
  assign rd_win  = bus.rd_req
                 && (!pick_any || wr_streak >= SW'(WR_BURST));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      tmr       <= '0;
      wr_streak <= '0;
      rd_tmr    <= '0;
      wen_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      ren_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      unique case (state)
        IDLE: begin
          if (rd_win) begin
            state     <= RD;
            ren_q     <= 1'b1;
            busy_q    <= 1'b1;
            wr_streak <= '0;
            rd_tmr    <= RW'(1);
          end else if (pick_any) begin
            state  <= WR;
            wen_q  <= pick_oh;
            rr_ptr <= ptr_nxt;
            tmr    <= TW'(1);
            busy_q <= 1'b1;
            if (wr_streak < SW'(WR_BURST))
              wr_streak <= wr_streak + SW'(1);
          end
        end
        WR: begin
          if (ack_hit) begin
            done_q <= wen_q;
            wen_q  <= '0;
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (tmr == TW'(ACK_TIMEOUT)) begin
            err_q  <= wen_q;
            wen_q  <= '0;
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        RD: begin
          if (!bus.rd_req
              || (pick_any && rd_tmr >= RW'(RD_MAX))) begin
            ren_q     <= 1'b0;
            state     <= IDLE;
            busy_q    <= 1'b0;
            wr_streak <= '0;
          end else if (rd_tmr < RW'(RD_MAX)) begin
            rd_tmr <= rd_tmr + RW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          wen_q  <= '0;
          ren_q  <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rf_wen  = wen_q;
  assign bus.rf_ren  = ren_q;
  assign bus.rd_gnt  = ren_q;
  assign bus.wr_done = done_q;
  assign bus.wr_err  = err_q;
  assign bus.busy    = busy_q;

  // The regfile drops writes while ren is high.
  a_rw_excl: assert property (
    @(posedge clk) disable iff (!reset)
      !((|bus.rf_wen) && bus.rf_ren)
  );

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench for regfile_wr_sched with a regfile ack model.
module tb_regfile_wr_sched;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  int unsigned ack_dly [3];
  int unsigned cnt [3];
  logic [2:0]  ack_m;

  regfile_wr_sched_if #(.N(3)) bus ();

  regfile_wr_sched dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regfile model: ack rises ack_dly cycles after wen; 0 = never.
  always_ff @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) cnt[i] <= 0;
      else if (bus.rf_wen[i]) cnt[i] <= cnt[i] + 1;
      else cnt[i] <= 0;
    end
  end

  always_comb begin
    ack_m = '0;
    for (int i = 0; i < 3; i++)
      ack_m[i] = bus.rf_wen[i] && (ack_dly[i] != 0)
               && (cnt[i] >= ack_dly[i]);
  end

  assign bus.rf_ack = ack_m;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    bus.wr_req = '0;
    bus.rd_req = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  function automatic logic [2:0] t4_wen(int c);
    if ((c >= 1 && c <= 2) || (c >= 4 && c <= 5)
        || (c >= 7 && c <= 8) || (c >= 10 && c <= 11)
        || (c >= 22 && c <= 23))
      return 3'b001;
    return 3'b000;
  endfunction

  logic [2:0] exp_g [4];
  logic [2:0] seen_done;
  int         ren_cnt;

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    bus.wr_req = '0;
    bus.rd_req = 1'b0;
    for (int i = 0; i < 3; i++) ack_dly[i] = 1;
    exp_g[0] = 3'b001;
    exp_g[1] = 3'b010;
    exp_g[2] = 3'b100;
    exp_g[3] = 3'b001;

    // Reset state
    step();
    chk("rst_wen", bus.rf_wen, 0);
    chk("rst_ren", bus.rf_ren, 0);
    chk("rst_gnt", bus.rd_gnt, 0);
    chk("rst_done", bus.wr_done, 0);
    chk("rst_err", bus.wr_err, 0);
    chk("rst_busy", bus.busy, 0);
    step();
    rst_n = 1'b1;

    // 1: single write, ack delay 1
    bus.wr_req = 3'b001;
    step();
    chk("t1_wen", bus.rf_wen, 3'b001);
    chk("t1_busy", bus.busy, 1);
    step();
    chk("t1_nodone", bus.wr_done, 0);
    step();
    chk("t1_done", bus.wr_done, 3'b001);
    chk("t1_wen_off", bus.rf_wen, 0);
    bus.wr_req = 3'b000;
    step();
    chk("t1_pulse", bus.wr_done, 0);
    chk("t1_idle", bus.busy, 0);

    // 2: all requesters held, grant order from fresh reset
    do_reset();
    bus.wr_req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t2_gnt%0d", k), bus.rf_wen, exp_g[k]);
      step();
      step();
      chk($sformatf("t2_gap%0d", k), bus.rf_wen, 0);
      chk($sformatf("t2_done%0d", k), bus.wr_done, exp_g[k]);
    end
    bus.wr_req = 3'b000;

    // 3: port 1 never acks
    do_reset();
    ack_dly[1] = 0;
    seen_done  = '0;
    bus.wr_req = 3'b010;
    step();
    chk("t3_wen", bus.rf_wen, 3'b010);
    for (int c = 2; c <= 16; c++) begin
      step();
      seen_done = seen_done | bus.wr_done;
    end
    chk("t3_wen_hold", bus.rf_wen, 3'b010);
    chk("t3_no_err_yet", bus.wr_err, 0);
    step();
    seen_done = seen_done | bus.wr_done;
    chk("t3_err", bus.wr_err, 3'b010);
    chk("t3_wen_off", bus.rf_wen, 0);
    chk("t3_no_done", seen_done, 0);
    bus.wr_req = 3'b000;
    step();
    chk("t3_err_pulse", bus.wr_err, 0);
    ack_dly[1] = 1;

    // 4: continuous read + write, burst/read-hold limits
    do_reset();
    bus.wr_req = 3'b001;
    bus.rd_req = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      step();
      chk($sformatf("t4_wen%0d", c), bus.rf_wen, t4_wen(c));
      chk($sformatf("t4_ren%0d", c), bus.rf_ren,
          (c >= 13 && c <= 20) ? 1 : 0);
      chk($sformatf("t4_gnt%0d", c), bus.rd_gnt, bus.rf_ren);
      chk($sformatf("t4_excl%0d", c),
          (|bus.rf_wen) && bus.rf_ren, 0);
    end

    // 5: read only, 20 cycles
    do_reset();
    bus.rd_req = 1'b1;
    ren_cnt    = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (bus.rf_ren) ren_cnt++;
    end
    chk("t5_ren_cycles", ren_cnt, 20);
    bus.rd_req = 1'b0;
    step();
    chk("t5_ren_off", bus.rf_ren, 0);
    chk("t5_idle", bus.busy, 0);

    // 6: reset in the middle of a port-2 write
    do_reset();
    ack_dly[2] = 0;
    bus.wr_req = 3'b100;
    step();
    chk("t6_wen", bus.rf_wen, 3'b100);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_wen", bus.rf_wen, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_done", bus.wr_done | bus.wr_err, 0);
    bus.wr_req = 3'b000;
    ack_dly[2] = 1;
    step();
    step();
    rst_n      = 1'b1;
    bus.wr_req = 3'b101;
    step();
    chk("t6_first", bus.rf_wen, 3'b001);
    step();
    step();
    chk("t6_done0", bus.wr_done, 3'b001);
    bus.wr_req = 3'b100;
    step();
    chk("t6_second", bus.rf_wen, 3'b100);
    step();
    step();
    chk("t6_done2", bus.wr_done, 3'b100);
    bus.wr_req = 3'b000;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
